db9_joy_reader: RTL and testbench

//  Multi-port DB9 joystick reader for the arcade tops. Replaces the hsync-clocked single-pair

---
 rtl/db9_joy_reader.sv | 165 ++++++++++++++++
 tb/tb_db9_joy_reader.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/db9_joy_reader.sv
// rtl/db9_joy_reader.sv - multi-port DB9 joystick reader (Atari/SMS, MD 3/6-button), frame-coherent outputs.
// Optional JOY_FILTER_EN: per-bit 2-frame debounce of joy_o at commit.
module db9_joy_reader #(
  parameter int NUM_PORTS   = 2,
  parameter int PHASE_DIV   = 384,
  parameter int IDLE_PHASES = 248
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [6*NUM_PORTS-1:0]  joy_i,
  output logic                    joy_sel_o,
  output logic [12*NUM_PORTS-1:0] joy_o,
  output logic [2*NUM_PORTS-1:0]  mode_o,
  output logic                    frame_done_o
);

  localparam int NPH   = 8 + IDLE_PHASES;
  localparam int DIV_W = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;
  localparam int PH_W  = $clog2(NPH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PHASE_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(NPH - 1);

  logic [DIV_W-1:0]        div_q, div_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic                    tick, commit;
  logic                    sel_q, sel_d;
  logic [6*NUM_PORTS-1:0]  sync1_q, sync2_q;
  logic [12*NUM_PORTS-1:0] stage_q, stage_d;
  logic [NUM_PORTS-1:0]    six_q, six_d;
  logic [NUM_PORTS-1:0]    md_q, md_d;
  logic [12*NUM_PORTS-1:0] joy_q, joy_d;
  logic [2*NUM_PORTS-1:0]  mode_q, mode_d;
  logic                    fd_q, fd_d;
`ifdef JOY_FILTER_EN
  logic [12*NUM_PORTS-1:0] prev_q, prev_d;
`endif

  // Phase sequencer: state register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_q   <= '0;
      phase_q <= '0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
    end
  end

  // Phase sequencer: next state
  always_comb begin
    tick    = (div_q == DIV_LAST);
    div_d   = tick ? '0 : div_q + 1'b1;
    phase_d = phase_q;
    if (tick) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
    end
  end

  assign commit = tick && (phase_q == PH_LAST);

  // Per-phase select drive and pin sampling; pins reflect the select level of the phase just ending
  always_comb begin
    sel_d   = sel_q;
    stage_d = stage_q;
    six_d   = six_q;
    md_d    = md_q;
    if (tick) begin
      case (phase_q)
        PH_W'(0): sel_d = 1'b0;
        PH_W'(1): sel_d = 1'b1;
        PH_W'(2): begin
          for (int n = 0; n < NUM_PORTS; n++) begin
            stage_d[12*n +: 6] = ~sync2_q[6*n +: 6];
            six_d[n]           = 1'b0;
          end
          sel_d = 1'b0;
        end
        PH_W'(3): begin
          for (int n = 0; n < NUM_PORTS; n++) begin
            if (!sync2_q[6*n+2] && !sync2_q[6*n+3]) begin
              md_d[n]            = 1'b1;
              stage_d[12*n+6]    = ~sync2_q[6*n+4];
              stage_d[12*n+7]    = ~sync2_q[6*n+5];
            end else begin
              md_d[n]            = 1'b0;
              stage_d[12*n+6 +: 2] = 2'b00;
            end
          end
          sel_d = 1'b1;
        end
        PH_W'(4): sel_d = 1'b0;
        PH_W'(5): begin
          for (int n = 0; n < NUM_PORTS; n++) begin
            if (sync2_q[6*n +: 4] == 4'b0000) six_d[n] = 1'b1;
          end
          sel_d = 1'b1;
        end
        PH_W'(6): begin
          for (int n = 0; n < NUM_PORTS; n++) begin
            stage_d[12*n+8 +: 4] = six_q[n] ? ~sync2_q[6*n +: 4] : 4'b0000;
          end
          sel_d = 1'b0;
        end
        default: sel_d = 1'b1;
      endcase
    end
  end

  // Frame commit
  always_comb begin
    joy_d  = joy_q;
    mode_d = mode_q;
    fd_d   = commit;
`ifdef JOY_FILTER_EN
    prev_d = prev_q;
`endif
    if (commit) begin
`ifdef JOY_FILTER_EN
      joy_d  = (stage_q & ~(stage_q ^ prev_q)) | (joy_q & (stage_q ^ prev_q));
      prev_d = stage_q;
`else
      joy_d  = stage_q;
`endif
      for (int n = 0; n < NUM_PORTS; n++) begin
        mode_d[2*n +: 2] = {six_q[n], md_q[n] & ~six_q[n]};
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      sel_q   <= 1'b1;
      stage_q <= '0;
      six_q   <= '0;
      md_q    <= '0;
      joy_q   <= '0;
      mode_q  <= '0;
      fd_q    <= 1'b0;
`ifdef JOY_FILTER_EN
      prev_q  <= '0;
`endif
    end else begin
      sync1_q <= joy_i;
      sync2_q <= sync1_q;
      sel_q   <= sel_d;
      stage_q <= stage_d;
      six_q   <= six_d;
      md_q    <= md_d;
      joy_q   <= joy_d;
      mode_q  <= mode_d;
      fd_q    <= fd_d;
`ifdef JOY_FILTER_EN
      prev_q  <= prev_d;
`endif
    end
  end

  assign joy_sel_o    = sel_q;
  assign joy_o        = joy_q;
  assign mode_o       = mode_q;
  assign frame_done_o = fd_q;

endmodule

// File: tb/tb_db9_joy_reader.sv
// tb/tb_db9_joy_reader.sv - directed self-checking bench for db9_joy_reader with behavioural pad models.
module tb_db9_joy_reader;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [11:0] joy_i;
  logic        joy_sel_o;
  logic [23:0] joy_o;
  logic [3:0]  mode_o;
  logic        frame_done_o;

  int          total = 0;
  int          bad   = 0;
  int          ptype0 = 0, ptype1 = 0;
  logic [11:0] btn0 = '0, btn1 = '0;
  int          cnt = 0;
  logic        sel_prev = 1'b1;
  logic        filt;

  db9_joy_reader #(.NUM_PORTS(2), .PHASE_DIV(4), .IDLE_PHASES(8)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .joy_i        (joy_i),
    .joy_sel_o    (joy_sel_o),
    .joy_o        (joy_o),
    .mode_o       (mode_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk_sys = ~clk_sys;

  // Pad model: type 0 none, 1 Atari, 2 MD 3-button, 3 MD 6-button; returns active-low {p9,p6,R,L,D,U}
  function automatic logic [5:0] pad(input int t, input logic [11:0] b, input logic sel, input int c);
    logic [5:0] pr;
    pr = 6'b0;
    case (t)
      1: pr = b[5:0];
      2, 3: begin
        if (sel) pr = (t == 3 && c == 3) ? {b[5], b[4], b[11], b[10], b[9], b[8]} : b[5:0];
        else     pr = (t == 3 && c == 3) ? {b[7], b[6], 4'hF} : {b[7], b[6], 2'b11, b[1], b[0]};
      end
      default: pr = 6'b0;
    endcase
    return ~pr;
  endfunction

  assign joy_i = {pad(ptype1, btn1, joy_sel_o, cnt), pad(ptype0, btn0, joy_sel_o, cnt)};

  // Counts select falling edges within a frame, like the pad's internal counter
  always @(posedge clk_sys) begin
    if (reset || frame_done_o) cnt <= 0;
    else if (sel_prev && !joy_sel_o) cnt <= cnt + 1;
    sel_prev <= joy_sel_o;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(posedge clk_sys); #1;
      n++;
    end while (!frame_done_o && n < 300);
    if (!frame_done_o) chk("frame_timeout", {31'b0, frame_done_o}, 32'd1);
  endtask

  initial begin
    int n, first, p;
`ifdef JOY_FILTER_EN
    filt = 1'b1;
`else
    filt = 1'b0;
`endif
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_sel", {31'b0, joy_sel_o}, 32'd1);
    chk("rst_joy", {8'b0, joy_o}, 32'd0);
    chk("rst_mode", {28'b0, mode_o}, 32'd0);
    chk("rst_fd", {31'b0, frame_done_o}, 32'd0);
    reset = 1'b0;

    n = 0;
    first = 0;
    while (first == 0 && n < 200) begin
      @(posedge clk_sys); #1;
      n++;
      if (n >= 5 && n % 4 == 1) begin
        p = n / 4 - 1;
        chk($sformatf("sel_p%0d", p), {31'b0, joy_sel_o}, (p >= 7) ? 32'd1 : 32'(p & 1));
      end
      if (frame_done_o) first = n;
    end
    chk("first_fd", first, 64);
    chk("idle_joy", {8'b0, joy_o}, 32'd0);
    @(posedge clk_sys); #1;
    chk("fd_pulse", {31'b0, frame_done_o}, 32'd0);
    wait_frame(n);
    chk("fd_period", n, 63);

    ptype0 = 1; btn0 = 12'h011;
    ptype1 = 2; btn1 = 12'h040;
    wait_frame(n);
    wait_frame(n);
    chk("atari_joy", {20'b0, joy_o[11:0]}, 32'h011);
    chk("atari_mode", {30'b0, mode_o[1:0]}, 32'd0);
    chk("md3_joy", {20'b0, joy_o[23:12]}, 32'h040);
    chk("md3_mode", {30'b0, mode_o[3:2]}, 32'd1);

    ptype0 = 3; btn0 = 12'hC00;
    ptype1 = 0; btn1 = 12'h000;
    wait_frame(n);
    wait_frame(n);
    chk("md6_joy", {20'b0, joy_o[11:0]}, 32'hC00);
    chk("md6_mode", {30'b0, mode_o[1:0]}, 32'd2);
    chk("none_joy", {20'b0, joy_o[23:12]}, 32'h000);
    chk("none_mode", {30'b0, mode_o[3:2]}, 32'd0);

    repeat (21) @(posedge clk_sys);
    #1;
    reset = 1'b1;
    @(posedge clk_sys); #1;
    chk("midrst_joy", {8'b0, joy_o}, 32'd0);
    chk("midrst_mode", {28'b0, mode_o}, 32'd0);
    chk("midrst_sel", {31'b0, joy_sel_o}, 32'd1);
    reset = 1'b0;
    wait_frame(n);
    chk("midrst_fd", n, 64);
    chk("midrst_mode6", {30'b0, mode_o[1:0]}, 32'd2);
    if (filt) begin
      chk("midrst_joy_hold", {20'b0, joy_o[11:0]}, 32'h000);
      wait_frame(n);
    end
    chk("midrst_joy6", {20'b0, joy_o[11:0]}, 32'hC00);

    ptype0 = 1; btn0 = 12'h000;
    wait_frame(n);
    wait_frame(n);
    chk("flt_clear", {20'b0, joy_o[11:0]}, 32'h000);
    btn0 = 12'h010;
    wait_frame(n);
    chk("flt_b1", {20'b0, joy_o[11:0]}, filt ? 32'h000 : 32'h010);
    btn0 = 12'h000;
    wait_frame(n);
    chk("flt_rel", {20'b0, joy_o[11:0]}, 32'h000);
    btn0 = 12'h010;
    wait_frame(n);
    chk("flt_b2a", {20'b0, joy_o[11:0]}, filt ? 32'h000 : 32'h010);
    wait_frame(n);
    chk("flt_b2b", {20'b0, joy_o[11:0]}, 32'h010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
